// File: rtl/axi_arbiter_nx1_if.sv
// Bus bundle for the NM:1 AXI arbiter: flattened per-master slave-side ports plus one memory-side port.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface axi_arbiter_nx1_if #(
  parameter int NM     = 2,
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic [NM*ID_W-1:0]   s_arid;
  logic [NM*ADDR_W-1:0] s_araddr;
  logic [NM*8-1:0]      s_arlen;
  logic [NM*3-1:0]      s_arsize;
  logic [NM*2-1:0]      s_arburst;
  logic [NM-1:0]        s_arvalid;
  logic [NM-1:0]        s_arready;

  logic [NM*ID_W-1:0]   s_rid;
  logic [NM*DATA_W-1:0] s_rdata;
  logic [NM*2-1:0]      s_rresp;
  logic [NM-1:0]        s_rlast;
  logic [NM-1:0]        s_rvalid;
  logic [NM-1:0]        s_rready;

  logic [NM*ID_W-1:0]   s_awid;
  logic [NM*ADDR_W-1:0] s_awaddr;
  logic [NM*8-1:0]      s_awlen;
  logic [NM*3-1:0]      s_awsize;
  logic [NM*2-1:0]      s_awburst;
  logic [NM-1:0]        s_awvalid;
  logic [NM-1:0]        s_awready;

  logic [NM*DATA_W-1:0] s_wdata;
  logic [NM*STRB_W-1:0] s_wstrb;
  logic [NM-1:0]        s_wlast;
  logic [NM-1:0]        s_wvalid;
  logic [NM-1:0]        s_wready;

  logic [NM*ID_W-1:0]   s_bid;
  logic [NM*2-1:0]      s_bresp;
  logic [NM-1:0]        s_bvalid;
  logic [NM-1:0]        s_bready;

  logic [ID_W-1:0]      m_arid;
  logic [ADDR_W-1:0]    m_araddr;
  logic [7:0]           m_arlen;
  logic [2:0]           m_arsize;
  logic [1:0]           m_arburst;
  logic                 m_arvalid;
  logic                 m_arready;

  logic [ID_W-1:0]      m_rid;
  logic [DATA_W-1:0]    m_rdata;
  logic [1:0]           m_rresp;
  logic                 m_rlast;
  logic                 m_rvalid;
  logic                 m_rready;

  logic [ID_W-1:0]      m_awid;
  logic [ADDR_W-1:0]    m_awaddr;
  logic [7:0]           m_awlen;
  logic [2:0]           m_awsize;
  logic [1:0]           m_awburst;
  logic                 m_awvalid;
  logic                 m_awready;

  logic [DATA_W-1:0]    m_wdata;
  logic [STRB_W-1:0]    m_wstrb;
  logic                 m_wlast;
  logic                 m_wvalid;
  logic                 m_wready;

  logic [ID_W-1:0]      m_bid;
  logic [1:0]           m_bresp;
  logic                 m_bvalid;
  logic                 m_bready;

  modport slave (
    input  s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid,
    output s_arready,
    output s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
    input  s_rready,
    input  s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awvalid,
    output s_awready,
    input  s_wdata, s_wstrb, s_wlast, s_wvalid,
    output s_wready,
    output s_bid, s_bresp, s_bvalid,
    input  s_bready,
    output m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
    input  m_arready,
    input  m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
    output m_rready,
    output m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
    input  m_awready,
    output m_wdata, m_wstrb, m_wlast, m_wvalid,
    input  m_wready,
    input  m_bid, m_bresp, m_bvalid,
    output m_bready
  );

  modport master (
    output s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid,
    input  s_arready,
    input  s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
    output s_rready,
    output s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awvalid,
    input  s_awready,
    output s_wdata, s_wstrb, s_wlast, s_wvalid,
    input  s_wready,
    input  s_bid, s_bresp, s_bvalid,
    output s_bready,
    input  m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
    output m_arready,
    output m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
    input  m_rready,
    input  m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
    output m_awready,
    input  m_wdata, m_wstrb, m_wlast, m_wvalid,
    output m_wready,
    output m_bid, m_bresp, m_bvalid,
    input  m_bready
  );
endinterface

// File: rtl/axi_arbiter_nx1.sv
// NM:1 AXI arbiter with independent single-outstanding read and write paths, round robin by default.
// Define AXI_ARB_FIXED_PRIO_EN for strict lowest-index-wins priority (no round-robin pointers).
module axi_arbiter_nx1 #(
  parameter int NM     = 2,
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic             clk,
  input logic             rst,
  axi_arbiter_nx1_if.slave bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = $clog2(NM);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;

  rd_state_t        rstate;
  wr_state_t        wstate;
  logic [PTR_W-1:0] gr, gw;
  logic [PTR_W-1:0] rwin, wwin;

`ifdef AXI_ARB_FIXED_PRIO_EN
  function automatic logic [PTR_W-1:0] pick(input logic [NM-1:0] req);
    logic [PTR_W-1:0] w;
    w = '0;
    for (int i = NM - 1; i >= 0; i--)
      if (req[i]) w = PTR_W'(i);
    return w;
  endfunction

  assign rwin = pick(bus.s_arvalid);
  assign wwin = pick(bus.s_awvalid);
`else
  logic [PTR_W-1:0] rptr, wptr;

  function automatic logic [PTR_W-1:0] pick(input logic [NM-1:0] req, input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] w;
    logic             found;
    int               idx;
    w     = '0;
    found = 1'b0;
    for (int i = 0; i < NM; i++) begin
      idx = (int'(ptr) + i) % NM;
      if (!found && req[idx]) begin
        w     = PTR_W'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  function automatic logic [PTR_W-1:0] after(input logic [PTR_W-1:0] w);
    return (int'(w) == NM - 1) ? '0 : w + 1'b1;
  endfunction

  assign rwin = pick(bus.s_arvalid, rptr);
  assign wwin = pick(bus.s_awvalid, wptr);

  // Pointers advance past the winner only when a grant is actually taken in the idle state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr <= '0;
      wptr <= '0;
    end else begin
      if (rstate == R_IDLE && |bus.s_arvalid) rptr <= after(rwin);
      if (wstate == W_IDLE && |bus.s_awvalid) wptr <= after(wwin);
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstate <= R_IDLE;
      gr     <= '0;
    end else begin
      case (rstate)
        R_IDLE: if (|bus.s_arvalid) begin
          gr     <= rwin;
          rstate <= R_ADDR;
        end
        R_ADDR: if (bus.s_arvalid[gr] && bus.m_arready) rstate <= R_DATA;
        R_DATA: if (bus.m_rvalid && bus.s_rready[gr] && bus.m_rlast) rstate <= R_IDLE;
        default: rstate <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wstate <= W_IDLE;
      gw     <= '0;
    end else begin
      case (wstate)
        W_IDLE: if (|bus.s_awvalid) begin
          gw     <= wwin;
          wstate <= W_ADDR;
        end
        W_ADDR: if (bus.s_awvalid[gw] && bus.m_awready) wstate <= W_DATA;
        W_DATA: if (bus.s_wvalid[gw] && bus.m_wready && bus.s_wlast[gw]) wstate <= W_RESP;
        W_RESP: if (bus.m_bvalid && bus.s_bready[gw]) wstate <= W_IDLE;
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // Routing is a pure function of the registered state and grant, so m_*valid never sees an m_*ready
  always_comb begin
    bus.s_arready = '0;
    bus.m_arid    = '0;
    bus.m_araddr  = '0;
    bus.m_arlen   = '0;
    bus.m_arsize  = '0;
    bus.m_arburst = '0;
    bus.m_arvalid = 1'b0;
    bus.s_rid     = '0;
    bus.s_rdata   = '0;
    bus.s_rresp   = '0;
    bus.s_rlast   = '0;
    bus.s_rvalid  = '0;
    bus.m_rready  = 1'b0;
    case (rstate)
      R_ADDR: begin
        bus.m_arid         = bus.s_arid[int'(gr)*ID_W +: ID_W];
        bus.m_araddr       = bus.s_araddr[int'(gr)*ADDR_W +: ADDR_W];
        bus.m_arlen        = bus.s_arlen[int'(gr)*8 +: 8];
        bus.m_arsize       = bus.s_arsize[int'(gr)*3 +: 3];
        bus.m_arburst      = bus.s_arburst[int'(gr)*2 +: 2];
        bus.m_arvalid      = bus.s_arvalid[gr];
        bus.s_arready[gr]  = bus.m_arready;
      end
      R_DATA: begin
        bus.s_rid          = {NM{bus.m_rid}};
        bus.s_rdata        = {NM{bus.m_rdata}};
        bus.s_rresp        = {NM{bus.m_rresp}};
        bus.s_rlast        = {NM{bus.m_rlast}};
        bus.s_rvalid[gr]   = bus.m_rvalid;
        bus.m_rready       = bus.s_rready[gr];
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.s_awready = '0;
    bus.m_awid    = '0;
    bus.m_awaddr  = '0;
    bus.m_awlen   = '0;
    bus.m_awsize  = '0;
    bus.m_awburst = '0;
    bus.m_awvalid = 1'b0;
    bus.s_wready  = '0;
    bus.m_wdata   = '0;
    bus.m_wstrb   = '0;
    bus.m_wlast   = 1'b0;
    bus.m_wvalid  = 1'b0;
    bus.s_bid     = '0;
    bus.s_bresp   = '0;
    bus.s_bvalid  = '0;
    bus.m_bready  = 1'b0;
    case (wstate)
      W_ADDR: begin
        bus.m_awid         = bus.s_awid[int'(gw)*ID_W +: ID_W];
        bus.m_awaddr       = bus.s_awaddr[int'(gw)*ADDR_W +: ADDR_W];
        bus.m_awlen        = bus.s_awlen[int'(gw)*8 +: 8];
        bus.m_awsize       = bus.s_awsize[int'(gw)*3 +: 3];
        bus.m_awburst      = bus.s_awburst[int'(gw)*2 +: 2];
        bus.m_awvalid      = bus.s_awvalid[gw];
        bus.s_awready[gw]  = bus.m_awready;
      end
      W_DATA: begin
        bus.m_wdata        = bus.s_wdata[int'(gw)*DATA_W +: DATA_W];
        bus.m_wstrb        = bus.s_wstrb[int'(gw)*STRB_W +: STRB_W];
        bus.m_wlast        = bus.s_wlast[gw];
        bus.m_wvalid       = bus.s_wvalid[gw];
        bus.s_wready[gw]   = bus.m_wready;
      end
      W_RESP: begin
        bus.s_bid          = {NM{bus.m_bid}};
        bus.s_bresp        = {NM{bus.m_bresp}};
        bus.s_bvalid[gw]   = bus.m_bvalid;
        bus.m_bready       = bus.s_bready[gw];
      end
      default: ;
    endcase
  end
endmodule
